// File: rtl/shift_add_mult_ctrl.sv
// Sequential 8x8 unsigned shift/add multiplier.
// A single 8-bit ripple adder is reused for all eight partial-product steps.

module adder_8bit (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic c;

  always_comb begin
    c = ci;
    s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

module shift_add_mult_ctrl #(
  parameter bit ZERO_SKIP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ZERO,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  m;
  logic [7:0]  m_next;
  logic [7:0]  acc;
  logic [7:0]  acc_next;
  logic [7:0]  q;
  logic [7:0]  q_next;
  logic [2:0]  cnt;
  logic [2:0]  cnt_next;
  logic [7:0]  addend;
  logic [7:0]  sum;
  logic        co;

  assign addend = q[0] ? m : 8'h00;

  adder_8bit u_adder (
    .x  (acc),
    .y  (addend),
    .ci (1'b0),
    .s  (sum),
    .co (co)
  );

  always_comb begin
    state_next = state;
    m_next     = m;
    acc_next   = acc;
    q_next     = q;
    cnt_next   = cnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          m_next   = a;
          q_next   = b;
          acc_next = 8'h00;
          cnt_next = 3'd0;
          if (ZERO_SKIP && (a == 8'h00 || b == 8'h00))
            state_next = S_ZERO;
          else
            state_next = S_RUN;
        end
      end
      S_RUN: begin
        // carry-out lands in A[7] so the product never overflows
        {acc_next, q_next} = {co, sum, q[7:1]};
        cnt_next = cnt + 3'd1;
        if (cnt == 3'd7)
          state_next = S_DONE;
      end
      S_ZERO: begin
        acc_next   = 8'h00;
        q_next     = 8'h00;
        state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (state == S_RUN) || (state == S_ZERO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      m     <= 8'h00;
      acc   <= 8'h00;
      q     <= 8'h00;
      cnt   <= 3'd0;
      done  <= 1'b0;
      p     <= 16'h0000;
    end else begin
      state <= state_next;
      m     <= m_next;
      acc   <= acc_next;
      q     <= q_next;
      cnt   <= cnt_next;
      done  <= (state_next == S_DONE);
      // p is loaded on entry to DONE so it is valid alongside done
      if (state_next == S_DONE)
        p <= {acc_next, q_next};
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: directed and random multiplies
// checked against plain arithmetic, with and without zero skipping.

module tb_shift_add_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        start [2];
  logic        busy  [2];
  logic        done  [2];
  logic [15:0] p     [2];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.ZERO_SKIP(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start[0]),
    .a     (a),
    .b     (b),
    .busy  (busy[0]),
    .done  (done[0]),
    .p     (p[0])
  );

  shift_add_mult_ctrl #(.ZERO_SKIP(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start[1]),
    .a     (a),
    .b     (b),
    .busy  (busy[1]),
    .done  (done[1]),
    .p     (p[1])
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: product is plain a*b; zero skip gives 2-cycle latency.
  function automatic int ref_lat(input int s, input logic [7:0] x,
                                 input logic [7:0] y);
    if (s == 1 && (x == 8'h00 || y == 8'h00))
      return 2;
    return 9;
  endfunction

  task automatic mul(input int s, input logic [7:0] x, input logic [7:0] y,
                     input string tag);
    logic [15:0] prev;
    int lat;
    int bc;
    bit hold_ok;
    prev    = p[s];
    bc      = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    a = x;
    b = y;
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    lat = 1;
    while (!done[s] && lat < 30) begin
      if (busy[s]) bc++;
      if (p[s] !== prev) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, ref_lat(s, x, y));
    check({tag, "_p"}, {16'h0, p[s]}, {16'h0, 16'(x) * 16'(y)});
    check({tag, "_busy_cycles"}, bc, ref_lat(s, x, y) - 1);
    check({tag, "_p_hold"}, {31'h0, hold_ok}, 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {30'h0, done[s], busy[s]}, 32'd0);
  endtask

  initial begin
    int t1;
    int t2;
    int ndone;
    int nbusy;
    bit hold_ok;
    logic [7:0] x;
    logic [7:0] y;
    start[0] = 1'b0;
    start[1] = 1'b0;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset%0d", s),
            {13'h0, busy[s], done[s], 1'b0, p[s]}, 32'd0);
    end
    rst_n = 1'b1;

    mul(0, 8'd13, 8'd11, "basic");
    mul(0, 8'hFF, 8'hFF, "max_ff");
    mul(0, 8'h80, 8'h02, "carry_80x02");

    // Reset in the middle of a run discards the partial result.
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_state", {13'h0, busy[0], done[0], 1'b0, p[0]}, 32'd0);
    mul(0, 8'd77, 8'd201, "after_reset");

    // A start pulse during RUN must not launch a second operation.
    @(negedge clk);
    a = 8'd3;
    b = 8'd5;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    a = 8'd7;
    b = 8'd7;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done[0]) begin
        ndone++;
        check("ignore_p", {16'h0, p[0]}, 32'd15);
      end
      if (i > 10 && busy[0]) nbusy++;
    end
    check("ignore_single_done", ndone, 1);
    check("ignore_no_rerun", nbusy, 0);

    mul(0, 8'h00, 8'hAB, "zero_noskip");
    mul(1, 8'h00, 8'hAB, "zero_skip");
    mul(1, 8'hAB, 8'h00, "zero_skip_b");
    mul(1, 8'h01, 8'h01, "one_skip");

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'd2;
    b = 8'd3;
    start[0] = 1'b1;
    @(negedge clk);
    a = 8'd4;
    b = 8'd5;
    t1 = -1;
    t2 = -1;
    hold_ok = 1'b1;
    for (int i = 1; i < 40 && t2 < 0; i++) begin
      if (done[0]) begin
        if (t1 < 0) begin
          t1 = i;
          check("b2b_first", {16'h0, p[0]}, 32'd6);
        end else begin
          t2 = i;
          start[0] = 1'b0;
          check("b2b_second", {16'h0, p[0]}, 32'd20);
        end
      end else if (t1 >= 0 && p[0] !== 16'd6) begin
        hold_ok = 1'b0;
      end
      if (t2 < 0) @(negedge clk);
    end
    start[0] = 1'b0;
    check("b2b_first_lat", t1, 9);
    check("b2b_spacing", t2 - t1, 10);
    check("b2b_p_hold", {31'h0, hold_ok}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("b2b_stopped", {31'h0, busy[0]}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) x = 8'h00;
      if ($urandom_range(0, 5) == 0) y = 8'h00;
      mul(i % 2, x, y, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
